// File: rtl/div_32_bit_seq_pkg.sv
// Shared constants and state encoding for the sequential signed divider.
package div_32_bit_seq_pkg;

    localparam int unsigned DIV_WIDTH      = 32;
    localparam int unsigned DIV_ITER_CNT_W = 6;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

    localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_32_bit_seq_neg.sv
// Two's-complement negation; used for operand magnitudes and result sign fix-up.
module neg_32_bit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    assign y = (~a) + WIDTH'(1);

endmodule

// File: rtl/div_32_bit_seq.sv
// Sequential signed restoring divider: quotient to LO, remainder to HI.
// One quotient bit per cycle; signs stripped in PREP and restored in FIX.
module div_32_bit_seq
    import div_32_bit_seq_pkg::*;
#(
    parameter int unsigned WIDTH      = DIV_WIDTH,
    parameter int unsigned ITER_CNT_W = DIV_ITER_CNT_W
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    div_state_e state_q, state_d;
    logic [WIDTH-1:0]      dividend_q, dividend_d;
    logic [WIDTH-1:0]      divisor_q, divisor_d;
    logic [WIDTH-1:0]      dvs_mag_q, dvs_mag_d;
    logic [WIDTH-1:0]      quo_q, quo_d;
    logic [WIDTH-1:0]      rem_q, rem_d;
    logic [ITER_CNT_W-1:0] cnt_q, cnt_d;
    logic                  q_neg_q, q_neg_d;
    logic                  r_neg_q, r_neg_d;
    logic                  zero_q, zero_d;
    logic [WIDTH-1:0]      quotient_q, quotient_d;
    logic [WIDTH-1:0]      remainder_q, remainder_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  dbz_q, dbz_d;

    logic [WIDTH-1:0] neg_a_in, neg_a_out;
    logic [WIDTH-1:0] neg_b_in, neg_b_out;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Negators serve operands in PREP and the magnitude results in FIX.
    assign neg_a_in = (state_q == FIX) ? quo_q : dividend_q;
    assign neg_b_in = (state_q == FIX) ? rem_q : divisor_q;

    neg_32_bit #(.WIDTH(WIDTH)) u_neg_a (.a(neg_a_in), .y(neg_a_out));
    neg_32_bit #(.WIDTH(WIDTH)) u_neg_b (.a(neg_b_in), .y(neg_b_out));

    // Stored remainder is always < |divisor|, so its 33rd bit is implicit zero.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_mag_q};

    always_comb begin
        state_d     = state_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        dvs_mag_d   = dvs_mag_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        zero_d      = zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dividend_d = dividend;
                    divisor_d  = divisor;
                    busy_d     = 1'b1;
                    dbz_d      = 1'b0;
                    state_d    = PREP;
                end
            end
            PREP: begin
                cnt_d = '0;
                if (divisor_q == '0) begin
                    // Route through FIX with no sign change so results land with done.
                    zero_d  = 1'b1;
                    quo_d   = WIDTH'(DBZ_QUOTIENT);
                    rem_d   = dividend_q;
                    q_neg_d = 1'b0;
                    r_neg_d = 1'b0;
                    state_d = FIX;
                end else begin
                    zero_d    = 1'b0;
                    q_neg_d   = dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1];
                    r_neg_d   = dividend_q[WIDTH-1];
                    rem_d     = '0;
                    quo_d     = dividend_q[WIDTH-1] ? neg_a_out : dividend_q;
                    dvs_mag_d = divisor_q[WIDTH-1] ? neg_b_out : divisor_q;
                    state_d   = ITER;
                end
            end
            ITER: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + ITER_CNT_W'(1);
                if (cnt_q == ITER_CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quotient_d  = q_neg_q ? neg_a_out : quo_q;
                remainder_d = r_neg_q ? neg_b_out : rem_q;
                dbz_d       = zero_q;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q     <= IDLE;
            dividend_q  <= '0;
            divisor_q   <= '0;
            dvs_mag_q   <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            dvs_mag_q   <= dvs_mag_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            zero_q      <= zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_32_bit_seq.sv
// Self-checking bench for div_32_bit_seq: directed corner cases plus random operands.
module tb_div_32_bit_seq;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    div_32_bit_seq dut (
        .clock      (clock),
        .clear      (clear),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: signed division truncating toward zero, with the divider's special cases.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic z);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        z  = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endfunction

    // One division; optionally raises a second start after edge pulse_at while busy.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input int pulse_at, input logic [31:0] a2, input logic [31:0] b2);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        int          lat;
        int          exp_lat;
        logic        busy_bad;
        lat      = 0;
        busy_bad = 1'b0;
        ref_div(a, b, eq, er, ez);
        exp_lat = (b == 32'd0) ? 2 : 34;
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clock);
            #1;
            if (done) begin
                lat = e;
                break;
            end
            if (!busy) busy_bad = 1'b1;
            if (e == pulse_at) begin
                start    = 1'b1;
                dividend = a2;
                divisor  = b2;
            end else begin
                start    = 1'b0;
                dividend = $urandom;
                divisor  = $urandom;
            end
        end
        start = 1'b0;
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("busy_before_done", 32'(busy_bad), 32'd0);
        check_eq("busy_at_done", 32'(busy), 32'd0);
        check_eq("quotient", quotient, eq);
        check_eq("remainder", remainder, er);
        check_eq("div_by_zero", 32'(div_by_zero), 32'(ez));
        @(posedge clock);
        #1;
        check_eq("done_one_cycle", 32'(done), 32'd0);
        check_eq("quotient_held", quotient, eq);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          done_seen;

        clear    = 1'b1;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        #12;
        check_eq("rst_quotient", quotient, 32'd0);
        check_eq("rst_remainder", remainder, 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clock);
        clear = 1'b0;

        run_div(32'd100, 32'd7, 0, 32'd0, 32'd0);
        run_div(-32'sd100, 32'd7, 0, 32'd0, 32'd0);
        run_div(32'd100, -32'sd7, 0, 32'd0, 32'd0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0, 32'd0);
        run_div(32'h7FFF_FFFF, 32'd1, 0, 32'd0, 32'd0);
        run_div(32'd5, 32'd0, 0, 32'd0, 32'd0);
        run_div(32'd9, 32'd3, 0, 32'd0, 32'd0);
        run_div(32'd1000, 32'd3, 10, 32'd8, 32'd2);

        // Asynchronous clear in the middle of the iterations.
        @(negedge clock);
        dividend = 32'd1000;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clock);
        #3;
        clear = 1'b1;
        #1;
        check_eq("clr_quotient", quotient, 32'd0);
        check_eq("clr_remainder", remainder, 32'd0);
        check_eq("clr_busy", 32'(busy), 32'd0);
        check_eq("clr_done", 32'(done), 32'd0);
        check_eq("clr_dbz", 32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clock);
        clear     = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (done || busy) done_seen++;
        end
        check_eq("clr_no_done", 32'(done_seen), 32'd0);
        run_div(32'd50, 32'd5, 0, 32'd0, 32'd0);

        for (int n = 0; n < 150; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = -32'($urandom_range(1, 1000));
                default: rb = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 65535));
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            run_div(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0,
                    $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
